// File: rtl/demux_1_to_8_rr_sched.sv
// Round-robin scheduler for a 1:8 demux: one-entry holding register, fair rotation over enabled channels.
// Optional DEMUX_SCHED_STATS_EN adds a 16-bit output transfer counter (xfer_count).
module demux_1_to_8_rr_sched #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        en_mask,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [2:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_valid,
    input  logic [7:0]        out_ready,
    output logic              busy
`ifdef DEMUX_SCHED_STATS_EN
    ,
    output logic [15:0]       xfer_count
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        ptr_r;
    logic [2:0]        sel_r;
    logic [2:0]        sel_nxt_s;
    logic [2:0]        base_s;
    logic [2:0]        pick_s;
    logic [DATA_W-1:0] data_r;
    logic [7:0]        out_valid_r;
    logic              busy_r;
    logic              xfer_s;
    logic              rdy_raw_s;
    logic              in_ready_s;
    logic              accept_s;

    // First enabled channel scanning upward from base, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] base);
        logic [2:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = base + 3'(i);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Handshake, channel pick and next-state decode.
    always_comb begin
        xfer_s      = 1'b0;
        rdy_raw_s   = 1'b0;
        base_s      = ptr_r;
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                rdy_raw_s = |en_mask;
                base_s    = ptr_r;
            end
            ST_HOLD: begin
                // A same-cycle accept rotates from the channel just served, not the stale ptr.
                xfer_s    = out_ready[sel_r];
                rdy_raw_s = out_ready[sel_r] & (|en_mask);
                base_s    = sel_r + 3'd1;
            end
            default: begin
                xfer_s    = 1'b0;
                rdy_raw_s = 1'b0;
                base_s    = ptr_r;
            end
        endcase
        in_ready_s = rdy_raw_s & ~rst;
        accept_s   = in_valid & in_ready_s;
        pick_s     = rr_pick(en_mask, base_s);
        if (accept_s) begin
            state_nxt_s = ST_HOLD;
        end else if (xfer_s) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            state_nxt_s = state_r;
        end
        sel_nxt_s = accept_s ? pick_s : sel_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointer, holding register and registered demux controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= 3'd0;
            sel_r       <= 3'd0;
            data_r      <= {DATA_W{1'b0}};
            out_valid_r <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            if (xfer_s) begin
                ptr_r <= sel_r + 3'd1;
            end else begin
                ptr_r <= ptr_r;
            end
            if (accept_s) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
            sel_r       <= sel_nxt_s;
            out_valid_r <= (state_nxt_s == ST_HOLD) ? (8'h01 << sel_nxt_s) : 8'h00;
            busy_r      <= (state_nxt_s == ST_HOLD);
        end
    end

`ifdef DEMUX_SCHED_STATS_EN
    logic [15:0] xfer_count_r;

    // Free-running count of completed output transfers, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_r <= 16'h0000;
        end else if (xfer_s) begin
            xfer_count_r <= xfer_count_r + 16'h0001;
        end else begin
            xfer_count_r <= xfer_count_r;
        end
    end

    assign xfer_count = xfer_count_r;
`endif

    assign in_ready  = in_ready_s;
    assign sel       = sel_r;
    assign out_data  = data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_demux_1_to_8_rr_sched.sv
// Self-checking bench for demux_1_to_8_rr_sched: behavioural model plus directed test-plan pins and random traffic.
module tb_demux_1_to_8_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] en_mask;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic       busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic [15:0] xfer_count;
`endif

    demux_1_to_8_rr_sched #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef DEMUX_SCHED_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: is an item held, on which channel, with what data; rotation pointer; transfer tally.
    bit       m_hold;
    int       m_ch;
    int       m_ptr;
    int       m_data;
    int       m_cnt;
    bit       m_sel_known;

    // Last observed DUT values for the literal pins.
    logic       obs_rdy;
    logic [2:0] obs_sel;
    logic [7:0] obs_data;
    logic [7:0] obs_valid;
    logic       obs_busy;
    logic [15:0] obs_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [7:0] en, input int base);
        for (int d = 0; d < 8; d++) begin
            if (en[(base + d) % 8]) return (base + d) % 8;
        end
        return -1;
    endfunction

    // One clock cycle: drive after the falling edge, check against the model, advance the model at the rising edge.
    task automatic step(input logic [7:0] en, input logic v, input logic [7:0] d,
                        input logic [7:0] ordy, input logic r);
        bit rdy;
        bit xfer;
        bit acc;
        en_mask   = en;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        #1;
        rdy = !r && (en != 8'h00) && (!m_hold || ordy[m_ch]);
        obs_rdy   = in_ready;
        obs_sel   = sel;
        obs_data  = out_data;
        obs_valid = out_valid;
        obs_busy  = busy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_ch) : 32'd0);
        chk("busy", 32'(busy), 32'(m_hold));
        if (m_sel_known) begin
            chk("sel", 32'(sel), 32'(m_ch));
            chk("out_data", 32'(out_data), 32'(m_data));
        end
`ifdef DEMUX_SCHED_STATS_EN
        obs_cnt = xfer_count;
        chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`else
        obs_cnt = 16'h0000;
`endif
        if (r) begin
            m_hold = 1'b0; m_ch = 0; m_ptr = 0; m_data = 0; m_cnt = 0; m_sel_known = 1'b1;
        end else begin
            xfer = m_hold && ordy[m_ch];
            acc  = v && rdy;
            if (xfer) begin
                m_ptr = (m_ch + 1) % 8;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (acc) begin
                m_ch = mpick(en, m_ptr);
                m_data = int'(d);
                m_hold = 1'b1;
                m_sel_known = 1'b1;
            end else if (xfer) begin
                m_hold = 1'b0;
                m_sel_known = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [2:0] skip_exp [6];

    initial begin
        skip_exp = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};
        rst = 1'b1; en_mask = 8'h00; in_valid = 1'b0; in_data = 8'h00; out_ready = 8'h00;
        @(posedge clk);
        @(negedge clk);
        m_hold = 1'b0; m_ch = 0; m_ptr = 0; m_data = 0; m_cnt = 0; m_sel_known = 1'b1;

        // Reset state then full rotation with wrap on the ninth item.
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b1, 8'hA0 + 8'(i), 8'hFF, 1'b0);
            if (i == 0) begin
                chk("reset_valid", 32'(obs_valid), 32'h00);
                chk("reset_sel", 32'(obs_sel), 32'd0);
                chk("reset_busy", 32'(obs_busy), 32'd0);
            end else begin
                chk("rot_sel", 32'(obs_sel), 32'((i - 1) % 8));
                chk("rot_valid", 32'(obs_valid), 32'd1 << ((i - 1) % 8));
                chk("rot_data", 32'(obs_data), 32'h9F + 32'(i));
            end
        end

        // Masked skip.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(8'hA5, (i < 6) ? 1'b1 : 1'b0, 8'(i), 8'hFF, 1'b0);
            if (i > 0) chk("skip_sel", 32'(obs_sel), 32'(skip_exp[i - 1]));
        end

        // Stall then pass-through.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(8'hFF, 1'b1, 8'hB0, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(8'hFF, 1'b1, 8'hB1, 8'h00, 1'b0);
            chk("stall_rdy", 32'(obs_rdy), 32'd0);
            chk("stall_sel", 32'(obs_sel), 32'd0);
            chk("stall_data", 32'(obs_data), 32'hB0);
        end
        step(8'hFF, 1'b1, 8'hB1, 8'h01, 1'b0);
        chk("pass_rdy", 32'(obs_rdy), 32'd1);
        step(8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("pass_sel", 32'(obs_sel), 32'd1);
        chk("pass_data", 32'(obs_data), 32'hB1);

        // Mask change while holding on channel 3.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(8'h08, 1'b1, 8'hC0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'hF7, 1'b1, 8'hC1, 8'hF7, 1'b0);
            chk("mask_hold_sel", 32'(obs_sel), 32'd3);
            chk("mask_hold_rdy", 32'(obs_rdy), 32'd0);
        end
        step(8'hF7, 1'b1, 8'hC1, 8'h08, 1'b0);
        step(8'hF7, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("mask_next_sel", 32'(obs_sel), 32'd4);

        // All channels disabled, then only channel 4.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b1, 8'hD0, 8'hFF, 1'b0);
            chk("off_rdy", 32'(obs_rdy), 32'd0);
            chk("off_valid", 32'(obs_valid), 32'h00);
        end
        step(8'h10, 1'b1, 8'hD1, 8'h00, 1'b0);
        chk("on_rdy", 32'(obs_rdy), 32'd1);
        step(8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("on_sel", 32'(obs_sel), 32'd4);

        // Mid-operation reset while holding on channel 6.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        step(8'h40, 1'b1, 8'hE0, 8'h00, 1'b0);
        step(8'hFF, 1'b1, 8'hE1, 8'h00, 1'b0);
        chk("pre_rst_sel", 32'(obs_sel), 32'd6);
        step(8'hFF, 1'b1, 8'hE1, 8'hFF, 1'b1);
        chk("rst_rdy", 32'(obs_rdy), 32'd0);
        step(8'hFF, 1'b1, 8'hE2, 8'h00, 1'b0);
        chk("post_rst_valid", 32'(obs_valid), 32'h00);
        chk("post_rst_busy", 32'(obs_busy), 32'd0);
        chk("post_rst_sel", 32'(obs_sel), 32'd0);
        chk("post_rst_cnt", 32'(obs_cnt), 32'd0);
        step(8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("post_rst_next", 32'(obs_sel), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] en_r;
            logic [7:0] ordy_r;
            en_r   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ordy_r = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step(en_r, 1'($urandom_range(0, 3) != 0), 8'($urandom), ordy_r,
                 1'($urandom_range(0, 99) == 0));
        end

`ifdef DEMUX_SCHED_STATS_EN
        // Counter wrap after 65536 transfers.
        step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1);
        for (int k = 0; k < 65538; k++) begin
            step(8'hFF, 1'b1, 8'(k), 8'hFF, 1'b0);
            if (k == 65536) chk("cnt_ffff", 32'(obs_cnt), 32'h0000FFFF);
        end
        chk("cnt_wrap", 32'(obs_cnt), 32'h00000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_to_8_rr_sched.md
# demux_1_to_8_rr_sched

Round-robin scheduler that distributes a single valid/ready input stream across eight destination channels. It sits in front of the 1:8 demultiplexer datapath and drives its 3-bit select (S2,S1,S0) together with per-channel valid strobes. A one-entry holding register decouples the source from the destinations. Enabled channels are served in fair rotation, and disabled or stalled channels never block the source beyond the item already committed to them.

## Interface
- DATA_W, 8, width of the data word routed through the block
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- en_mask  in  8  channel enable; bit k=1 makes channel k eligible for new items
- in_valid  in  1  source presents in_data
- in_data  in  DATA_W  source data word
- in_ready  out  1  block accepts in_data this cycle
- sel  out  3  demux select {S2,S1,S0}; channel currently owning the held item
- out_data  out  DATA_W  held data word, common to all channels
- out_valid  out  8  one-hot; bit sel=1 while an item is held, else all 0
- out_ready  in  8  per-channel destination ready
- busy  out  1  1 while an item is held

## Operation
- State machine:
  - EMPTY: no item held.
  - HOLD: item held, committed to channel sel.
- Round-robin pointer ptr[2:0] gives the first channel to consider for the next item.
- Channel pick: the first channel c in the order ptr, ptr+1, …, ptr+7 (mod 8) with en_mask[c]=1. The pick is evaluated on en_mask in the accept cycle.
- EMPTY state:
  - in_ready = |en_mask.
  - On in_valid && in_ready: in_data goes into the holding register, sel becomes the picked channel, and the state moves to HOLD.
- HOLD state:
  - out_valid = 1 << sel.
  - The transfer completes when out_ready[sel]=1.
  - On transfer, ptr becomes sel+1 (mod 8, so 7 wraps to 0).
  - in_ready = out_ready[sel] && |en_mask_after, where en_mask_after is en_mask. This gives pass-through: a new item is accepted in the same cycle the held item leaves.
  - Simultaneous transfer and accept: the new item's channel is picked starting from sel+1, not from the old ptr. The state stays HOLD.
  - Transfer with no accept: the state moves to EMPTY.
- Committed items are never re-routed or dropped. Clearing en_mask[sel] while in HOLD does not move the held item, which waits for out_ready[sel].
- out_ready bits of non-selected channels are ignored.
- An all-zero en_mask blocks acceptance (in_ready=0). It does not affect an item already held.

## Timing
- Reset values (rst=1 at a clock edge):
  - State is EMPTY; ptr, sel and out_data are 0.
  - out_valid is 8'h00 and busy is 0.
- Reset mid-operation discards the held item without delivering it. in_ready is 0 during any cycle with rst=1.
- in_ready is combinational from the state, en_mask and out_ready. out_valid, sel, out_data and busy are registered, so they are glitch-free for the demux.
- Latency: an item accepted at edge N appears on out_valid/out_data/sel after edge N; it is visible in cycle N+1.
- Throughput: one item per cycle when the selected destination is ready every cycle.
- Handshake: a transfer occurs on the edge where valid and ready are both 1. out_data and sel are stable from the accept edge until the transfer edge.

## Configuration
- DEMUX_SCHED_STATS_EN:
  - Defined: adds output xfer_count[15:0], which increments by 1 on every output transfer and wraps 16'hFFFF→0. It resets to 0.
  - Not defined: the port and counter are absent and the rest of the behaviour is identical.

## Test plan
- Reset then rotation: en_mask=8'hFF, in_valid held 1 with data 8'hA0..8'hA7, out_ready=8'hFF. Required response: sel goes 0,1,…,7 on consecutive cycles, out_valid goes 8'h01…8'h80, and the 9th item goes to sel=0 (wrap).
- Masked skip: en_mask=8'b1010_0101, out_ready=8'hFF, six items. Required response: sel sequence 0,2,5,7,0,2.
- Stall and pass-through: out_ready[sel]=0 for 5 cycles while in_valid=1. Required response: in_ready=0, out_data and sel stable. When out_ready[sel] rises, the held item transfers and the next item is accepted in the same cycle and routed to sel+1.
- Mask change in HOLD: an item held on channel 3, then en_mask[3] cleared. Required response: the item stays on sel=3 until out_ready[3]=1, and the next item skips channel 3.
- All channels disabled: en_mask=8'h00 with in_valid=1. Required response: in_ready=0 and out_valid=8'h00 indefinitely. Setting en_mask=8'h10 makes the next item land on sel=4.
- Mid-operation reset: rst=1 while holding an item on channel 6. Required response after the edge: out_valid=8'h00, busy=0, sel=0, and ptr is 0, so the next item goes to the first enabled channel from 0. With DEMUX_SCHED_STATS_EN defined, xfer_count=0 after reset and the count reaches 16'h0000 again after 65536 transfers.
